// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter owner for the single-cycle CPU.
// Selects the next PC from decoder/ALU qualifiers, tracks the loop-start
// address, instruction-memory stalls and the halted state.
// Optional build macro FETCH_RETIRE_COUNT_EN adds a 16-bit committed
// instruction counter on output RetireCount.
module fetch_sequencer #(
    parameter int PC_WIDTH     = 8,
    parameter int RESET_VECTOR = 0,
    parameter int HALT_VECTOR  = 200
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] InstrAddr,
    input  logic                InstrValid,
    input  logic [2:0]          BranchDest,
    input  logic                Halt,
    input  logic                SkipIfNot1Flag,
    input  logic                IfDoneFlag,
    input  logic                AluZero,
    input  logic [PC_WIDTH-1:0] JumpTarget,
    output logic                Stalled,
    output logic                Halted,
    output logic                Retire,
`ifdef FETCH_RETIRE_COUNT_EN
    output logic [15:0]         RetireCount,
`endif
    output logic                BadDest
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] RST_PC  = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH-1:0] HALT_PC = PC_WIDTH'(HALT_VECTOR);
    localparam logic [PC_WIDTH-1:0] ONE     = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] TWO     = PC_WIDTH'(2);

    state_t              state_q,   state_d;
    logic [PC_WIDTH-1:0] pc_q,      pc_d;
    logic [PC_WIDTH-1:0] loop_pc_q, loop_pc_d;
    logic                stalled_q, stalled_d;
    logic                halted_q,  halted_d;
    logic                retire_q,  retire_d;
    logic                bad_q,     bad_d;
    logic                commit_d;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] pc_plus2;

    // Sequential increments wrap naturally at the PC width.
    assign pc_plus1 = pc_q + ONE;
    assign pc_plus2 = pc_q + TWO;

    // Next-state, next-PC and output selection for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        loop_pc_d = loop_pc_q;
        stalled_d = 1'b0;
        halted_d  = 1'b0;
        retire_d  = 1'b0;
        bad_d     = bad_q;
        commit_d  = 1'b0;
        case (state_q)
            ST_RUN, ST_WAIT: begin
                if (!InstrValid) begin
                    // Memory not ready: hold PC, ignore the decoder.
                    state_d   = ST_WAIT;
                    stalled_d = 1'b1;
                end else begin
                    commit_d = 1'b1;
                    state_d  = ST_RUN;
                    retire_d = 1'b1;
                    if (Halt) begin
                        // Halt outranks every branch, including BranchDest=6.
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                        retire_d = 1'b0;
                    end else if (SkipIfNot1Flag) begin
                        pc_d = AluZero ? pc_plus1 : pc_plus2;
                    end else begin
                        case (BranchDest)
                            3'd0: pc_d = pc_plus1;
                            3'd1: pc_d = JumpTarget;
                            3'd2: pc_d = loop_pc_q;
                            3'd3: pc_d = AluZero ? pc_plus2 : pc_plus1;
                            3'd4: begin
                                pc_d      = pc_plus1;
                                loop_pc_d = pc_plus1;
                            end
                            3'd5: pc_d = (IfDoneFlag && AluZero) ? JumpTarget : pc_plus1;
                            3'd6: begin
                                pc_d     = HALT_PC;
                                state_d  = ST_HALTED;
                                halted_d = 1'b1;
                                retire_d = 1'b0;
                            end
                            3'd7: begin
                                pc_d  = pc_plus1;
                                bad_d = 1'b1;
                            end
                            default: pc_d = pc_plus1;
                        endcase
                    end
                end
            end
            ST_HALTED: begin
                // Frozen until reset.
                halted_d = 1'b1;
            end
            default: begin
                // Illegal encoding: recover to RUN without moving the PC.
                state_d = ST_RUN;
            end
        endcase
    end

    // State, PC and registered status outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RST_PC;
            loop_pc_q <= RST_PC;
            stalled_q <= 1'b0;
            halted_q  <= 1'b0;
            retire_q  <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            loop_pc_q <= loop_pc_d;
            stalled_q <= stalled_d;
            halted_q  <= halted_d;
            retire_q  <= retire_d;
            bad_q     <= bad_d;
        end
    end

`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] count_q;

    // Committed-instruction counter, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'd0;
        end else if (commit_d) begin
            count_q <= count_q + 16'd1;
        end else begin
            count_q <= count_q;
        end
    end

    assign RetireCount = count_q;
`endif

    assign InstrAddr = pc_q;
    assign Stalled   = stalled_q;
    assign Halted    = halted_q;
    assign Retire    = retire_q;
    assign BadDest   = bad_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a behavioural
// reference model of the next-PC rules.
module tb_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] InstrAddr;
    logic       InstrValid;
    logic [2:0] BranchDest;
    logic       Halt;
    logic       SkipIfNot1Flag;
    logic       IfDoneFlag;
    logic       AluZero;
    logic [7:0] JumpTarget;
    logic       Stalled;
    logic       Halted;
    logic       Retire;
    logic       BadDest;
`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] RetireCount;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_pc, m_loop, m_count;
    bit m_halted, m_stalled, m_retire, m_bad;

    fetch_sequencer #(.PC_WIDTH(8), .RESET_VECTOR(0), .HALT_VECTOR(200)) dut (
        .clk(clk), .reset(reset), .InstrAddr(InstrAddr), .InstrValid(InstrValid),
        .BranchDest(BranchDest), .Halt(Halt), .SkipIfNot1Flag(SkipIfNot1Flag),
        .IfDoneFlag(IfDoneFlag), .AluZero(AluZero), .JumpTarget(JumpTarget),
        .Stalled(Stalled), .Halted(Halted), .Retire(Retire),
`ifdef FETCH_RETIRE_COUNT_EN
        .RetireCount(RetireCount),
`endif
        .BadDest(BadDest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare outputs.
    task automatic step(input bit rst, input bit iv, input int bd, input bit h,
                        input bit s, input bit d, input bit z, input int jt);
        reset = rst; InstrValid = iv; BranchDest = 3'(bd); Halt = h;
        SkipIfNot1Flag = s; IfDoneFlag = d; AluZero = z; JumpTarget = 8'(jt);
        @(posedge clk);
        if (rst) begin
            m_pc = 0; m_loop = 0; m_halted = 0; m_stalled = 0;
            m_retire = 0; m_bad = 0; m_count = 0;
        end else if (m_halted) begin
            m_retire = 0; m_stalled = 0;
        end else if (!iv) begin
            m_stalled = 1; m_retire = 0;
        end else begin
            m_stalled = 0; m_retire = 1;
            m_count = (m_count + 1) % 65536;
            if (h) begin
                m_halted = 1; m_retire = 0;
            end else if (s) begin
                m_pc = (m_pc + (z ? 1 : 2)) % 256;
            end else begin
                case (bd)
                    1: m_pc = jt;
                    2: m_pc = m_loop;
                    3: m_pc = (m_pc + (z ? 2 : 1)) % 256;
                    4: begin m_pc = (m_pc + 1) % 256; m_loop = m_pc; end
                    5: m_pc = (d && z) ? jt : (m_pc + 1) % 256;
                    6: begin m_pc = 200; m_halted = 1; m_retire = 0; end
                    7: begin m_pc = (m_pc + 1) % 256; m_bad = 1; end
                    default: m_pc = (m_pc + 1) % 256;
                endcase
            end
        end
        #1;
        check("InstrAddr", 32'(InstrAddr), 32'(m_pc));
        check("Stalled",   32'(Stalled),   32'(m_stalled));
        check("Halted",    32'(Halted),    32'(m_halted));
        check("Retire",    32'(Retire),    32'(m_retire));
        check("BadDest",   32'(BadDest),   32'(m_bad));
`ifdef FETCH_RETIRE_COUNT_EN
        check("RetireCount", 32'(RetireCount), 32'(m_count));
`endif
    endtask

    task automatic go(input int bd, input int jt);
        step(1'b0, 1'b1, bd, 1'b0, 1'b0, 1'b0, 1'b0, jt);
    endtask

    initial begin
        int halted_cycles;
        bit rr, iv, h, s, d, z;
        int bd;
        halted_cycles = 0;
        reset = 1'b1; InstrValid = 1'b0; BranchDest = 3'd0; Halt = 1'b0;
        SkipIfNot1Flag = 1'b0; IfDoneFlag = 1'b0; AluZero = 1'b0; JumpTarget = 8'd0;

        // Directed walk through the key behaviours
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        go(0, 0); go(0, 0); go(0, 0);                       // 1,2,3
        go(1, 5); go(4, 0);                                 // 5 -> 6, loop=6
        go(0, 0); go(0, 0); go(0, 0); go(2, 0);             // 9 -> 6
        check("loop_return", 32'(InstrAddr), 32'd6);
        go(1, 10);
        step(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);     // 12
        check("skip_z0", 32'(InstrAddr), 32'd12);
        go(1, 10);
        step(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0);     // 11
        check("skip_z1", 32'(InstrAddr), 32'd11);
        go(1, 20);
        step(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 99);
        step(1'b0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 99);
        check("stall_hold", 32'(InstrAddr), 32'd20);
        go(1, 8'h40);
        check("stall_jump", 32'(InstrAddr), 32'h40);
        go(1, 255);
        step(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 0);     // wrap to 1
        check("wrap_plus2", 32'(InstrAddr), 32'd1);
        go(7, 0); go(0, 0);
        check("bad_sticky", 32'(BadDest), 32'd1);
        step(1'b0, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 0);     // Halt beats dest 6
        check("halt_priority", 32'(InstrAddr), 32'd3);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        go(6, 0); go(1, 77); go(0, 0);
        check("halt_vector", 32'(InstrAddr), 32'd200);
        step(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("reset_exit", 32'(Halted), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 99) < 1) || (halted_cycles > 3);
            iv = ($urandom_range(0, 99) < 80);
            h  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 20);
            d  = $urandom_range(0, 1);
            z  = $urandom_range(0, 1);
            bd = $urandom_range(0, 7);
            if (bd == 6 && $urandom_range(0, 3) != 0) bd = 0;
            step(rr, iv, bd, h, s, d, z, $urandom_range(0, 255));
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
